rx_message_buffer: RTL and testbench

//  Receive-message buffer directly downstream of the USB-PD Rx state machine.
//  - Captures the bytes the Rx block emits on oDIR_WRITE/oDATA_to_Buffer.
//  - Holds one complete message locked until the TCPM reads it and clears the alert.
//  - Drives the RX_SOP_MSG_STATUS and RX_BUF_OVERFLOW alert bits that merge into ALERT[15:0].

---
 rtl/rx_buf_pkg.sv | 46 ++++
 rtl/rx_buf_ram.sv | 46 ++++
 rtl/rx_message_buffer.sv | 170 +++++++++++++++++
 tb/tb_rx_message_buffer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_buf_pkg.sv
// -----------------------------------------------------------------------------
// rx_buf_pkg
// Shared definitions for the USB-PD receive-message buffer:
//   - default geometry (data width, depth, address width)
//   - control state encoding
//   - frame-type codes carried alongside a received message
//   - bit positions of the buffer's contributions to ALERT[15:0]
//   - count saturation helper
// -----------------------------------------------------------------------------
package rx_buf_pkg;

    localparam int RX_DW    = 8;
    localparam int RX_DEPTH = 32;
    localparam int RX_AW    = 5;

    localparam int ALERT_RX_SOP_MSG_STATUS_BIT = 2;
    localparam int ALERT_RX_BUF_OVERFLOW_BIT   = 10;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_HELD    = 2'd2,
        ST_READING = 2'd3
    } rx_buf_state_e;

    typedef enum logic [2:0] {
        FT_SOP         = 3'b000,
        FT_SOP_P       = 3'b001,
        FT_SOP_PP      = 3'b010,
        FT_SOP_DBG_P   = 3'b011,
        FT_SOP_DBG_PP  = 3'b100,
        FT_CABLE_RESET = 3'b110
    } rx_frame_type_e;

    // Clamp a reported byte count to what the buffer can physically hold.
    function automatic logic [7:0] sat_count(input logic [7:0] cnt, input logic [7:0] depth);
        logic [7:0] res;
        if (cnt > depth) begin
            res = depth;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

endpackage

// File: rtl/rx_buf_ram.sv
// -----------------------------------------------------------------------------
// rx_buf_ram
// DEPTH x DW storage for one received message. One write port, one
// synchronous read port (data appears the cycle after i_re). No reset: the
// contents are only meaningful once written by the Rx side.
// Ports:
//   CLK      clock, rising edge
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_re     read enable; captures mem[i_raddr] into o_rdata
//   i_raddr  read address
//   o_rdata  registered read data
// -----------------------------------------------------------------------------
module rx_buf_ram
    import rx_buf_pkg::*;
#(
    parameter int DW    = RX_DW,
    parameter int DEPTH = RX_DEPTH,
    parameter int AW    = RX_AW
) (
    input  logic          CLK,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Storage write and registered read.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/rx_message_buffer.sv
// -----------------------------------------------------------------------------
// rx_message_buffer
// Receive-message buffer sitting behind the USB-PD Rx state machine. Captures
// the bytes of one message, locks it once the Rx side reports it accepted,
// lets the TCPM pop it byte by byte and releases it on the RX alert clear.
// Ports:
//   CLK, reset               clock; synchronous active-low reset
//   iWR_EN/iDIR_WRITE/iDATA_IN  byte write from the Rx block
//   iMSG_DONE, iMSG_ABORT    message accepted / discarded (1-cycle pulses)
//   iRX_BUF_FRAME_TYPE       frame type of the message being received
//   iRECEIVE_BYTE_COUNT      byte count of the message being received
//   iRD_EN                   TCPM pop request
//   iALERT_CLR               TCPM clear of RX status; frees the buffer
//   oDATA_OUT, oDATA_VALID   popped byte, valid one cycle after iRD_EN
//   oRECEIVE_BYTE_COUNT      latched (saturated) byte count
//   oRX_BUF_FRAME_TYPE       latched frame type
//   oRX_SOP_MSG_STATUS       ALERT bit 2 contribution
//   oRX_BUF_OVERFLOW         ALERT bit 10 contribution
//   oBUF_BUSY                a message is held or being read
// -----------------------------------------------------------------------------
module rx_message_buffer
    import rx_buf_pkg::*;
#(
    parameter int DW    = RX_DW,
    parameter int DEPTH = RX_DEPTH,
    parameter int AW    = RX_AW
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          iWR_EN,
    input  logic [7:0]    iDIR_WRITE,
    input  logic [DW-1:0] iDATA_IN,
    input  logic          iMSG_DONE,
    input  logic          iMSG_ABORT,
    input  logic [2:0]    iRX_BUF_FRAME_TYPE,
    input  logic [7:0]    iRECEIVE_BYTE_COUNT,
    input  logic          iRD_EN,
    input  logic          iALERT_CLR,
    output logic [DW-1:0] oDATA_OUT,
    output logic          oDATA_VALID,
    output logic [7:0]    oRECEIVE_BYTE_COUNT,
    output logic [2:0]    oRX_BUF_FRAME_TYPE,
    output logic          oRX_SOP_MSG_STATUS,
    output logic          oRX_BUF_OVERFLOW,
    output logic          oBUF_BUSY
);

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    rx_buf_state_e r_state;
    logic [AW:0]   r_fill_cnt;
    logic [7:0]    r_rd_ptr;
    logic [7:0]    r_count;
    logic [2:0]    r_frame_type;
    logic          r_sop_status;
    logic          r_overflow;
    logic          r_data_valid;

    logic          w_addr_ok;
    logic          w_can_fill;
    logic          w_ram_we;
    logic          w_pop;
    logic [AW:0]   w_wr_next;
    logic [AW-1:0] w_rd_addr;
    logic [DW-1:0] w_ram_q;

    assign w_addr_ok  = (iDIR_WRITE < DEPTH_B);
    assign w_can_fill = (r_state == ST_EMPTY) || (r_state == ST_FILLING);
    // A held message is never touched by the Rx side, so the RAM write is
    // gated by state as well as by address range.
    assign w_ram_we   = iWR_EN && w_addr_ok && w_can_fill;
    assign w_wr_next  = {1'b0, iDIR_WRITE[AW-1:0]} + {{AW{1'b0}}, 1'b1};
    // The HELD->READING transition is itself the first pop (address 0).
    assign w_pop      = iRD_EN && !iALERT_CLR &&
                        ((r_state == ST_HELD) ||
                         ((r_state == ST_READING) && (r_rd_ptr < r_count)));
    assign w_rd_addr  = (r_state == ST_HELD) ? {AW{1'b0}} : r_rd_ptr[AW-1:0];

    rx_buf_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .CLK     (CLK),
        .i_we    (w_ram_we),
        .i_waddr (iDIR_WRITE[AW-1:0]),
        .i_wdata (iDATA_IN),
        .i_re    (w_pop),
        .i_raddr (w_rd_addr),
        .o_rdata (w_ram_q)
    );

    // Buffer control FSM with its registered status outputs.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state      <= ST_EMPTY;
            r_fill_cnt   <= '0;
            r_rd_ptr     <= 8'd0;
            r_count      <= 8'd0;
            r_frame_type <= 3'b000;
            r_sop_status <= 1'b0;
            r_overflow   <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_pop;
            case (r_state)
                ST_EMPTY: begin
                    if (iWR_EN) begin
                        if (w_addr_ok) begin
                            r_fill_cnt <= w_wr_next;
                        end else begin
                            r_fill_cnt <= '0;
                            r_overflow <= 1'b1;
                        end
                        r_state <= ST_FILLING;
                    end
                end
                ST_FILLING: begin
                    if (iWR_EN && !w_addr_ok) begin
                        r_overflow <= 1'b1;
                    end
                    // A zero-length "done" carries nothing to hold: discard it.
                    if (iMSG_ABORT || (iMSG_DONE && (iRECEIVE_BYTE_COUNT == 8'd0))) begin
                        r_state    <= ST_EMPTY;
                        r_fill_cnt <= '0;
                    end else if (iMSG_DONE) begin
                        r_count      <= sat_count(iRECEIVE_BYTE_COUNT, DEPTH_B);
                        r_frame_type <= iRX_BUF_FRAME_TYPE;
                        r_sop_status <= 1'b1;
                        r_rd_ptr     <= 8'd0;
                        r_state      <= ST_HELD;
                    end else if (iWR_EN && w_addr_ok && (w_wr_next > r_fill_cnt)) begin
                        r_fill_cnt <= w_wr_next;
                    end
                end
                ST_HELD, ST_READING: begin
                    if (iALERT_CLR) begin
                        r_state      <= ST_EMPTY;
                        r_sop_status <= 1'b0;
                        r_overflow   <= 1'b0;
                        r_rd_ptr     <= 8'd0;
                        r_count      <= 8'd0;
                        r_fill_cnt   <= '0;
                    end else begin
                        if (iWR_EN) begin
                            r_overflow <= 1'b1;
                        end
                        if (w_pop) begin
                            r_state  <= ST_READING;
                            r_rd_ptr <= (r_state == ST_HELD) ? 8'd1 : (r_rd_ptr + 8'd1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    // The RAM read register is not reset, so the byte is only exposed while valid.
    assign oDATA_OUT           = r_data_valid ? w_ram_q : {DW{1'b0}};
    assign oDATA_VALID         = r_data_valid;
    assign oRECEIVE_BYTE_COUNT = r_count;
    assign oRX_BUF_FRAME_TYPE  = r_frame_type;
    assign oRX_SOP_MSG_STATUS  = r_sop_status;
    assign oRX_BUF_OVERFLOW    = r_overflow;
    assign oBUF_BUSY           = (r_state == ST_HELD) || (r_state == ST_READING);

endmodule

// File: tb/tb_rx_message_buffer.sv
// -----------------------------------------------------------------------------
// tb_rx_message_buffer
// Directed scenarios plus randomized messages for rx_message_buffer. The
// reference model tracks the buffer as "idle / filling / holding a message"
// with a byte array, a read index and the alert bits.
// -----------------------------------------------------------------------------
`timescale 1ns/1ns
module tb_rx_message_buffer;

    logic       CLK;
    logic       reset;
    logic       iWR_EN;
    logic [7:0] iDIR_WRITE;
    logic [7:0] iDATA_IN;
    logic       iMSG_DONE;
    logic       iMSG_ABORT;
    logic [2:0] iRX_BUF_FRAME_TYPE;
    logic [7:0] iRECEIVE_BYTE_COUNT;
    logic       iRD_EN;
    logic       iALERT_CLR;
    logic [7:0] oDATA_OUT;
    logic       oDATA_VALID;
    logic [7:0] oRECEIVE_BYTE_COUNT;
    logic [2:0] oRX_BUF_FRAME_TYPE;
    logic       oRX_SOP_MSG_STATUS;
    logic       oRX_BUF_OVERFLOW;
    logic       oBUF_BUSY;

    rx_message_buffer dut (
        .CLK                 (CLK),
        .reset               (reset),
        .iWR_EN              (iWR_EN),
        .iDIR_WRITE          (iDIR_WRITE),
        .iDATA_IN            (iDATA_IN),
        .iMSG_DONE           (iMSG_DONE),
        .iMSG_ABORT          (iMSG_ABORT),
        .iRX_BUF_FRAME_TYPE  (iRX_BUF_FRAME_TYPE),
        .iRECEIVE_BYTE_COUNT (iRECEIVE_BYTE_COUNT),
        .iRD_EN              (iRD_EN),
        .iALERT_CLR          (iALERT_CLR),
        .oDATA_OUT           (oDATA_OUT),
        .oDATA_VALID         (oDATA_VALID),
        .oRECEIVE_BYTE_COUNT (oRECEIVE_BYTE_COUNT),
        .oRX_BUF_FRAME_TYPE  (oRX_BUF_FRAME_TYPE),
        .oRX_SOP_MSG_STATUS  (oRX_SOP_MSG_STATUS),
        .oRX_BUF_OVERFLOW    (oRX_BUF_OVERFLOW),
        .oBUF_BUSY           (oBUF_BUSY)
    );

    // Period 2: posedges at 1,3 fall inside the 4-unit reset window.
    initial CLK = 1'b0;
    always #1 CLK = ~CLK;

    localparam int P_IDLE = 0;
    localparam int P_FILL = 1;
    localparam int P_HOLD = 2;

    int         n_checks;
    int         n_fail;
    string      cur_tag;
    logic [7:0] m_mem [32];
    int         m_phase;
    int         m_cnt;
    int         m_type;
    int         m_rd;
    bit         m_stat;
    bit         m_ovf;
    int         len, ty, cnt, sel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0h expected %0h", cur_tag, tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        iWR_EN = 1'b0; iDIR_WRITE = 8'd0; iDATA_IN = 8'd0; iMSG_DONE = 1'b0;
        iMSG_ABORT = 1'b0; iRX_BUF_FRAME_TYPE = 3'd0; iRECEIVE_BYTE_COUNT = 8'd0;
        iRD_EN = 1'b0; iALERT_CLR = 1'b0;
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_cnt = 0; m_type = 0; m_rd = 0; m_stat = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic chk_zero();
        chk("valid", 32'(oDATA_VALID), 32'd0);
        chk("data", 32'(oDATA_OUT), 32'd0);
        chk("count", 32'(oRECEIVE_BYTE_COUNT), 32'd0);
        chk("ftype", 32'(oRX_BUF_FRAME_TYPE), 32'd0);
        chk("sop", 32'(oRX_SOP_MSG_STATUS), 32'd0);
        chk("ovf", 32'(oRX_BUF_OVERFLOW), 32'd0);
        chk("busy", 32'(oBUF_BUSY), 32'd0);
    endtask

    // One clock cycle of stimulus, model update and output comparison.
    task automatic cyc(input bit wr, input int addr, input int data, input bit dn, input bit ab,
                       input int bc, input int ft, input bit rd, input bit cl);
        bit         ev;
        logic [7:0] ed;
        iWR_EN = wr; iDIR_WRITE = 8'(addr); iDATA_IN = 8'(data); iMSG_DONE = dn;
        iMSG_ABORT = ab; iRECEIVE_BYTE_COUNT = 8'(bc); iRX_BUF_FRAME_TYPE = 3'(ft);
        iRD_EN = rd; iALERT_CLR = cl;
        ev = 1'b0; ed = 8'd0;
        if (m_phase == P_IDLE || m_phase == P_FILL) begin
            if (wr) begin
                if (addr < 32) m_mem[addr] = 8'(data);
                else m_ovf = 1'b1;
            end
            if (m_phase == P_FILL && (ab || (dn && bc == 0))) begin
                m_phase = P_IDLE;
            end else if (m_phase == P_FILL && dn) begin
                m_cnt = (bc > 32) ? 32 : bc; m_type = ft; m_stat = 1'b1; m_rd = 0; m_phase = P_HOLD;
            end else if (wr) begin
                m_phase = P_FILL;
            end
        end else begin
            if (cl) begin
                m_phase = P_IDLE; m_stat = 1'b0; m_ovf = 1'b0; m_cnt = 0; m_rd = 0;
            end else begin
                if (wr) m_ovf = 1'b1;
                if (rd && m_rd < m_cnt) begin
                    ev = 1'b1; ed = m_mem[m_rd]; m_rd++;
                end
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        idle_inputs();
        chk("valid", 32'(oDATA_VALID), 32'(ev));
        if (ev) chk("data", 32'(oDATA_OUT), 32'(ed));
        chk("count", 32'(oRECEIVE_BYTE_COUNT), 32'(m_cnt));
        chk("ftype", 32'(oRX_BUF_FRAME_TYPE), 32'(m_type));
        chk("sop", 32'(oRX_SOP_MSG_STATUS), 32'(m_stat));
        chk("ovf", 32'(oRX_BUF_OVERFLOW), 32'(m_ovf));
        chk("busy", 32'(oBUF_BUSY), 32'(m_phase == P_HOLD));
    endtask

    task automatic wr(input int a, input int d);    cyc(1'b1, a, d, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0); endtask
    task automatic done(input int c, input int t);  cyc(1'b0, 0, 0, 1'b1, 1'b0, c, t, 1'b0, 1'b0); endtask
    task automatic abort_msg();                     cyc(1'b0, 0, 0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0); endtask
    task automatic pop();                           cyc(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0); endtask
    task automatic clr();                           cyc(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1); endtask

    task automatic apply_reset();
        reset = 1'b0;
        idle_inputs();
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b1;
        model_reset();
        chk_zero();
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cur_tag = "reset";
        idle_inputs();
        model_reset();
        reset = 1'b0;
        #4;
        reset = 1'b1;
        chk_zero();

        // Give every RAM location a known value before anything reads it.
        cur_tag = "preload";
        for (int a = 0; a < 32; a++) wr(a, a ^ 8'h3C);
        abort_msg();

        cur_tag = "t1_normal";
        wr(0, 8'h99); wr(1, 8'h11); wr(2, 8'h22); wr(3, 8'h33); wr(4, 8'h44);
        done(5, 0);
        chk("cnt5", 32'(oRECEIVE_BYTE_COUNT), 32'd5);
        for (int p = 0; p < 6; p++) pop();
        clr();

        cur_tag = "t2_abort";
        wr(0, 8'hA1); wr(1, 8'hA2); wr(2, 8'hA3);
        abort_msg();
        wr(0, 8'h5C); wr(1, 8'hC5);
        done(2, 1);
        pop(); pop(); pop();
        clr();

        cur_tag = "t3_ovf_held";
        wr(0, 8'h12); wr(1, 8'h34); wr(2, 8'h56);
        done(3, 2);
        wr(0, 8'hAA);
        chk("ovf1", 32'(oRX_BUF_OVERFLOW), 32'd1);
        pop();
        chk("orig", 32'(oDATA_OUT), 32'h12);
        cyc(1'b1, 1, 8'hBB, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        wr(0, 8'h01); done(1, 0); clr();

        cur_tag = "t4_cable";
        wr(0, 8'h10);
        wr(32, 8'hEE);
        done(40, 6);
        chk("sat", 32'(oRECEIVE_BYTE_COUNT), 32'd32);
        pop(); pop();
        clr();

        cur_tag = "t5_simul";
        wr(0, 8'h01); wr(1, 8'h02); wr(2, 8'h03);
        cyc(1'b1, 3, 8'h77, 1'b1, 1'b0, 4, 3, 1'b0, 1'b0);
        for (int p = 0; p < 4; p++) pop();
        clr();
        wr(0, 8'h31); wr(1, 8'h32); done(2, 4);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        pop();

        cur_tag = "t6_reset";
        wr(0, 8'hD0); wr(1, 8'hD1); wr(2, 8'hD2); wr(3, 8'hD3);
        done(4, 0);
        pop(); pop();
        apply_reset();
        wr(0, 8'hE0); wr(1, 8'hE1); done(2, 0);
        pop(); pop(); pop();
        clr();

        cur_tag = "random";
        for (int m = 0; m < 14; m++) begin
            len = int'($urandom_range(1, 30));
            ty  = int'($urandom_range(0, 7));
            for (int a = 0; a < len; a++) wr(a, int'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) wr(int'($urandom_range(32, 255)), 8'h5A);
            sel = int'($urandom_range(0, 5));
            if (sel == 0) begin
                abort_msg();
            end else begin
                cnt = (sel == 1) ? int'($urandom_range(31, 60)) : len;
                done(cnt, ty);
                for (int p = 0; p < cnt + 2; p++) begin
                    cyc(($urandom_range(0, 4) == 0), int'($urandom_range(0, 31)),
                        int'($urandom_range(0, 255)), 1'b0, 1'b0, 0, 0,
                        ($urandom_range(0, 3) != 0), 1'b0);
                end
                clr();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
